// File: rtl/mips_alu_pc_unit_if.sv
// Execute-stage bundle: next-PC/enable in, PC and branch target out, decoded instruction fields and operands in, ALU/HI/LO/branch results out.
// Purely a wiring bundle; no latency and no flow control of its own.
interface mips_alu_pc_unit_if;
  logic        clk_enable;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] branch_address;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [4:0]  rt_instr;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic [31:0] alu_result;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        branch_taken;

  modport master (
    output clk_enable, pc_in, opcode, funct, shamt, immediate, rt_instr, rs_content, rt_content,
    input  pc_out, pc_plus4, branch_address, alu_result, hi_out, lo_out, branch_taken
  );

  modport slave (
    input  clk_enable, pc_in, opcode, funct, shamt, immediate, rt_instr, rs_content, rt_content,
    output pc_out, pc_plus4, branch_address, alu_result, hi_out, lo_out, branch_taken
  );
endinterface

// File: rtl/mips_alu_pc_unit.sv
// Single-cycle MIPS execute core: PC register, branch-target adder, ALU with mult/div and branch compare.
// PC updates one edge after clk_enable; all ALU outputs are combinational; no backpressure (clk_enable stalls PC only).
module mips_alu_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_alu_pc_unit_if.slave         bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_BEQ   = 6'h04, OP_BNE  = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU   = 6'h0B, OP_ANDI   = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI     = 6'h0F, OP_LB     = 6'h20, OP_LH    = 6'h21, OP_LWL  = 6'h22,
                         OP_LW      = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25, OP_LWR  = 6'h26,
                         OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_MTHI = 6'h11, FN_MTLO  = 6'h13,
                         FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B,
                         FN_ADDU = 6'h21, FN_SUBU  = 6'h23, FN_AND  = 6'h24, FN_OR    = 6'h25,
                         FN_XOR  = 6'h26, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0] RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;

  logic [31:0] pc_q;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] sext_imm;
  logic [31:0] zext_imm;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else if (bus.clk_enable) begin
      pc_q <= bus.pc_in;
    end
  end

  assign rs       = bus.rs_content;
  assign rt       = bus.rt_content;
  assign sext_imm = {{16{bus.immediate[15]}}, bus.immediate};
  assign zext_imm = {16'h0000, bus.immediate};

  assign bus.pc_out         = pc_q;
  assign bus.pc_plus4       = pc_q + 32'd4;
  assign bus.branch_address = bus.pc_plus4 + {sext_imm[29:0], 2'b00};

  // Products: both widths computed in 64 bits so HI holds the full upper word.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'h0, rs} * {32'h0, rt};

  // Signed divide goes through magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] sdiv_q;
  logic [31:0] sdiv_r;
  logic [31:0] udiv_q;
  logic [31:0] udiv_r;
  logic        div_by_zero;

  assign div_by_zero = (rt == 32'h0);
  assign rs_mag      = rs[31] ? (32'h0 - rs) : rs;
  assign rt_mag      = rt[31] ? (32'h0 - rt) : rt;

  always_comb begin
    mag_q  = 32'h0;
    mag_r  = 32'h0;
    udiv_q = 32'h0;
    udiv_r = 32'h0;
    if (!div_by_zero) begin
      mag_q  = rs_mag / rt_mag;
      mag_r  = rs_mag % rt_mag;
      udiv_q = rs / rt;
      udiv_r = rs % rt;
    end
  end

  assign sdiv_q = (rs[31] ^ rt[31]) ? (32'h0 - mag_q) : mag_q;
  assign sdiv_r = rs[31] ? (32'h0 - mag_r) : mag_r;

  logic        rs_is_zero;
  logic        rs_is_neg;

  assign rs_is_zero = (rs == 32'h0);
  assign rs_is_neg  = rs[31];

  always_comb begin
    bus.alu_result   = 32'h0;
    bus.hi_out       = 32'h0;
    bus.lo_out       = 32'h0;
    bus.branch_taken = 1'b0;

    case (bus.opcode)
      OP_SPECIAL: begin
        case (bus.funct)
          FN_SLL:   bus.alu_result = rt << bus.shamt;
          FN_SRL:   bus.alu_result = rt >> bus.shamt;
          FN_SRA:   bus.alu_result = $signed(rt) >>> bus.shamt;
          FN_SLLV:  bus.alu_result = rt << rs[4:0];
          FN_SRLV:  bus.alu_result = rt >> rs[4:0];
          FN_SRAV:  bus.alu_result = $signed(rt) >>> rs[4:0];
          FN_ADDU:  bus.alu_result = rs + rt;
          FN_SUBU:  bus.alu_result = rs - rt;
          FN_AND:   bus.alu_result = rs & rt;
          FN_OR:    bus.alu_result = rs | rt;
          FN_XOR:   bus.alu_result = rs ^ rt;
          FN_SLT:   bus.alu_result = {31'h0, ($signed(rs) < $signed(rt))};
          FN_SLTU:  bus.alu_result = {31'h0, (rs < rt)};
          FN_MTHI:  bus.hi_out     = rs;
          FN_MTLO:  bus.lo_out     = rs;
          FN_MULT: begin
            bus.hi_out = prod_s[63:32];
            bus.lo_out = prod_s[31:0];
          end
          FN_MULTU: begin
            bus.hi_out = prod_u[63:32];
            bus.lo_out = prod_u[31:0];
          end
          FN_DIV: begin
            bus.hi_out = sdiv_r;
            bus.lo_out = sdiv_q;
          end
          FN_DIVU: begin
            bus.hi_out = udiv_r;
            bus.lo_out = udiv_q;
          end
          default: ;
        endcase
      end

      OP_REGIMM: begin
        case (bus.rt_instr)
          RI_BLTZ, RI_BLTZAL: bus.branch_taken = rs_is_neg;
          RI_BGEZ, RI_BGEZAL: bus.branch_taken = !rs_is_neg;
          default:            bus.branch_taken = 1'b0;
        endcase
      end

      OP_BEQ:   bus.branch_taken = (rs == rt);
      OP_BNE:   bus.branch_taken = (rs != rt);
      OP_BLEZ:  bus.branch_taken = rs_is_neg || rs_is_zero;
      OP_BGTZ:  bus.branch_taken = !rs_is_neg && !rs_is_zero;

      OP_ADDIU: bus.alu_result = rs + sext_imm;
      OP_SLTI:  bus.alu_result = {31'h0, ($signed(rs) < $signed(sext_imm))};
      OP_SLTIU: bus.alu_result = {31'h0, (rs < sext_imm)};
      OP_ANDI:  bus.alu_result = rs & zext_imm;
      OP_ORI:   bus.alu_result = rs | zext_imm;
      OP_XORI:  bus.alu_result = rs ^ zext_imm;
      OP_LUI:   bus.alu_result = {bus.immediate, 16'h0000};

      // Raw byte address; alignment and byte lanes are resolved by the memory side.
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW:
                bus.alu_result = rs + sext_imm;

      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_alu_pc_unit.sv
// Directed bench for mips_alu_pc_unit: PC reset/hold/advance, branch target, ALU, mult/div, branches, addresses.
`timescale 1ns/1ps
module tb_mips_alu_pc_unit;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  mips_alu_pc_unit_if bus ();

  mips_alu_pc_unit #(
    .RESET_VECTOR(32'hBFC0_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [4:0] rti,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.opcode     = op;
    bus.funct      = fn;
    bus.shamt      = sh;
    bus.immediate  = imm;
    bus.rt_instr   = rti;
    bus.rs_content = rs;
    bus.rt_content = rt;
    #1;
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                     input logic [15:0] imm, input logic [4:0] rti,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] exp_alu, input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo, input logic exp_br);
    drive(op, fn, sh, imm, rti, rs, rt);
    check({tag, ".alu"}, bus.alu_result, exp_alu);
    check({tag, ".hi"},  bus.hi_out, exp_hi);
    check({tag, ".lo"},  bus.lo_out, exp_lo);
    check({tag, ".br"},  {31'h0, bus.branch_taken}, {31'h0, exp_br});
  endtask

  initial begin
    n_total        = 0;
    n_pass         = 0;
    reset          = 1'b1;
    bus.clk_enable = 1'b0;
    bus.pc_in      = 32'h0;
    bus.opcode     = 6'h0;
    bus.funct      = 6'h0;
    bus.shamt      = 5'h0;
    bus.immediate  = 16'h0;
    bus.rt_instr   = 5'h0;
    bus.rs_content = 32'h0;
    bus.rt_content = 32'h0;

    // Reset and hold
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst.pc",    bus.pc_out,   32'hBFC0_0000);
    check("rst.pc4",   bus.pc_plus4, 32'hBFC0_0004);
    repeat (2) @(posedge clk);
    #1;
    check("hold.pc",   bus.pc_out,   32'hBFC0_0000);

    drive(6'h04, 6'h00, 5'd0, 16'hFFFF, 5'd0, 32'h0, 32'h0);
    check("bta.neg",   bus.branch_address, 32'hBFC0_0000);
    drive(6'h04, 6'h00, 5'd0, 16'h0003, 5'd0, 32'h0, 32'h0);
    check("bta.pos",   bus.branch_address, 32'hBFC0_0010);

    // Advance PC
    bus.clk_enable = 1'b1;
    bus.pc_in      = 32'h0040_0000;
    @(posedge clk); #1;
    bus.clk_enable = 1'b0;
    check("adv.pc",    bus.pc_out,   32'h0040_0000);
    check("adv.pc4",   bus.pc_plus4, 32'h0040_0004);
    check("adv.bta",   bus.branch_address, 32'h0040_0010);
    @(posedge clk); #1;
    check("adv.hold",  bus.pc_out,   32'h0040_0000);

    //  tag      op     fn     sh    imm       rti    rs             rt             alu            hi             lo             br
    run("addu",  6'h00, 6'h21, 5'd0, 16'h0000, 5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,         32'h0,         1'b0);
    run("subu",  6'h00, 6'h23, 5'd0, 16'h0000, 5'h00, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0,         32'h0,         1'b0);
    run("slt",   6'h00, 6'h2A, 5'd0, 16'h0000, 5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,         32'h0,         1'b0);
    run("sltu",  6'h00, 6'h2B, 5'd0, 16'h0000, 5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,         32'h0,         1'b0);
    run("sra",   6'h00, 6'h03, 5'd4, 16'h0000, 5'h00, 32'h00000000, 32'h80000000, 32'hF8000000, 32'h0,         32'h0,         1'b0);
    run("srl",   6'h00, 6'h02, 5'd4, 16'h0000, 5'h00, 32'h00000000, 32'h80000000, 32'h08000000, 32'h0,         32'h0,         1'b0);
    run("sllv",  6'h00, 6'h04, 5'd0, 16'h0000, 5'h00, 32'h00000024, 32'h00000001, 32'h00000010, 32'h0,         32'h0,         1'b0);
    run("srav",  6'h00, 6'h07, 5'd0, 16'h0000, 5'h00, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 32'h0,         32'h0,         1'b0);
    run("xor",   6'h00, 6'h26, 5'd0, 16'h0000, 5'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,         32'h0,         1'b0);
    run("jalr",  6'h00, 6'h09, 5'd0, 16'h0000, 5'h00, 32'h12345678, 32'h00000001, 32'h00000000, 32'h0,         32'h0,         1'b0);
    run("lui",   6'h0F, 6'h00, 5'd0, 16'h1234, 5'h00, 32'hFFFFFFFF, 32'h0,         32'h12340000, 32'h0,         32'h0,         1'b0);
    run("ori",   6'h0D, 6'h00, 5'd0, 16'h8001, 5'h00, 32'hFFFF0000, 32'h0,         32'hFFFF8001, 32'h0,         32'h0,         1'b0);
    run("addiu", 6'h09, 6'h00, 5'd0, 16'hFFFF, 5'h00, 32'h00000010, 32'h0,         32'h0000000F, 32'h0,         32'h0,         1'b0);
    run("slti",  6'h0A, 6'h00, 5'd0, 16'hFFFF, 5'h00, 32'h00000005, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b0);
    run("sltiu", 6'h0B, 6'h00, 5'd0, 16'hFFFF, 5'h00, 32'h00000005, 32'h0,         32'h00000001, 32'h0,         32'h0,         1'b0);
    run("mult",  6'h00, 6'h18, 5'd0, 16'h0000, 5'h00, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run("multu", 6'h00, 6'h19, 5'd0, 16'h0000, 5'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("div",   6'h00, 6'h1A, 5'd0, 16'h0000, 5'h00, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div2",  6'h00, 6'h1A, 5'd0, 16'h0000, 5'h00, 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run("divov", 6'h00, 6'h1A, 5'd0, 16'h0000, 5'h00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0);
    run("div0",  6'h00, 6'h1A, 5'd0, 16'h0000, 5'h00, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0);
    run("divu",  6'h00, 6'h1B, 5'd0, 16'h0000, 5'h00, 32'hFFFFFFFF, 32'h00000010, 32'h00000000, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
    run("divu0", 6'h00, 6'h1B, 5'd0, 16'h0000, 5'h00, 32'h00000010, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0);
    run("mthi",  6'h00, 6'h11, 5'd0, 16'h0000, 5'h00, 32'hAABBCCDD, 32'h0,         32'h00000000, 32'hAABBCCDD, 32'h00000000, 1'b0);
    run("mtlo",  6'h00, 6'h13, 5'd0, 16'h0000, 5'h00, 32'h11223344, 32'h0,         32'h00000000, 32'h00000000, 32'h11223344, 1'b0);
    run("bgez",  6'h01, 6'h00, 5'd0, 16'h0004, 5'h01, 32'h00000000, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b1);
    run("bltz",  6'h01, 6'h00, 5'd0, 16'h0004, 5'h00, 32'h00000000, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b0);
    run("bltzal",6'h01, 6'h00, 5'd0, 16'h0004, 5'h10, 32'h80000000, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b1);
    run("rimmx", 6'h01, 6'h00, 5'd0, 16'h0004, 5'h02, 32'h80000000, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b0);
    run("bne",   6'h05, 6'h00, 5'd0, 16'h0004, 5'h00, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0,         32'h0,         1'b0);
    run("beq",   6'h04, 6'h00, 5'd0, 16'h0004, 5'h00, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0,         32'h0,         1'b1);
    run("blez",  6'h06, 6'h00, 5'd0, 16'h0004, 5'h00, 32'h80000000, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b1);
    run("bgtz",  6'h07, 6'h00, 5'd0, 16'h0004, 5'h00, 32'h00000000, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b0);
    run("bgtz1", 6'h07, 6'h00, 5'd0, 16'h0004, 5'h00, 32'h00000001, 32'h0,         32'h00000000, 32'h0,         32'h0,         1'b1);
    run("lw",    6'h23, 6'h00, 5'd0, 16'hFFFC, 5'h00, 32'h00001000, 32'h0,         32'h00000FFC, 32'h0,         32'h0,         1'b0);
    run("sb",    6'h28, 6'h00, 5'd0, 16'h0001, 5'h00, 32'h00000003, 32'h0,         32'h00000004, 32'h0,         32'h0,         1'b0);
    run("unk",   6'h3F, 6'h21, 5'd0, 16'h1234, 5'h00, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0,         32'h0,         1'b0);

    // Reset dominates clk_enable mid-run
    bus.clk_enable = 1'b1;
    bus.pc_in      = 32'h1234_5678;
    @(posedge clk); #1;
    check("run.pc",    bus.pc_out, 32'h1234_5678);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid.rst",   bus.pc_out, 32'hBFC0_0000);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post.rst",  bus.pc_out, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
